// File: rtl/mem_port_arbiter.sv
// Single-port DRAM arbiter between instruction fetch (IF) and load/store unit (LSU), one outstanding transaction.
// Optional performance counters are enabled by defining MEM_ARB_PERF_CNT_EN.
module mem_port_arbiter #(
  parameter int MAX_IF_WAIT = 4,
  parameter int CNT_W       = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [3:0]  lsu_be_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic        lsu_gnt_o,
  output logic        lsu_rvalid_o,
  output logic [31:0] lsu_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        busy_o,
`ifdef MEM_ARB_PERF_CNT_EN
  output logic [CNT_W-1:0] if_stall_cnt_o,
  output logic [CNT_W-1:0] lsu_stall_cnt_o,
  output logic [CNT_W-1:0] conflict_cnt_o,
`endif
  output logic        protocol_err_o
);

  localparam int            CW        = (MAX_IF_WAIT > 0) ? $clog2(MAX_IF_WAIT + 1) : 1;
  localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_IF_WAIT);
  localparam bit            STARVE_EN = (MAX_IF_WAIT > 0);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HOLD = 2'd1, ST_RESP = 2'd2} state_t;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_IF = 2'd1, OWN_LSU = 2'd2} owner_t;

  state_t        state_r, state_s;
  owner_t        owner_r, owner_s;
  owner_t        sel_s;
  logic [CW-1:0] starve_r, starve_s;
  logic          protocol_err_r;
  logic          conflict_s;

  assign conflict_s = if_req_i & lsu_req_i;

  // State, owner, starvation counter and sticky error flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r        <= ST_IDLE;
      owner_r        <= OWN_NONE;
      starve_r       <= {CW{1'b0}};
      protocol_err_r <= 1'b0;
    end else begin
      state_r        <= state_s;
      owner_r        <= owner_s;
      starve_r       <= starve_s;
      protocol_err_r <= protocol_err_r | (mem_rvalid_i & (state_r != ST_RESP));
    end
  end

  // Next-state, arbitration and output routing; everything held at 0 while reset is low
  always_comb begin
    state_s      = state_r;
    owner_s      = owner_r;
    starve_s     = starve_r;
    sel_s        = OWN_NONE;
    if_gnt_o     = 1'b0;
    lsu_gnt_o    = 1'b0;
    if_rvalid_o  = 1'b0;
    lsu_rvalid_o = 1'b0;
    if_rdata_o   = 32'h0000_0000;
    lsu_rdata_o  = 32'h0000_0000;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_be_o     = 4'h0;
    mem_addr_o   = 32'h0000_0000;
    mem_wdata_o  = 32'h0000_0000;
    busy_o       = 1'b0;
    if (!reset) begin
      state_s = ST_IDLE;
      owner_s = OWN_NONE;
    end else begin
      busy_o = (state_r != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          // IF overtakes LSU only once it has lost MAX_IF_WAIT conflicts in a row
          if (if_req_i && (!lsu_req_i || (STARVE_EN && (starve_r == MAX_CNT)))) begin
            sel_s = OWN_IF;
          end else if (lsu_req_i) begin
            sel_s = OWN_LSU;
          end else begin
            sel_s = OWN_NONE;
          end
          if (sel_s != OWN_NONE) begin
            owner_s = sel_s;
            state_s = mem_gnt_i ? ST_RESP : ST_HOLD;
          end else begin
            owner_s = OWN_NONE;
          end
          if (conflict_s && (sel_s == OWN_LSU) && (starve_r < MAX_CNT)) begin
            starve_s = starve_r + CW'(1);
          end else begin
            starve_s = starve_r;
          end
        end
        ST_HOLD: begin
          if ((owner_r == OWN_IF && if_req_i) || (owner_r == OWN_LSU && lsu_req_i)) begin
            sel_s   = owner_r;
            state_s = mem_gnt_i ? ST_RESP : ST_HOLD;
          end else begin
            sel_s   = OWN_NONE;
            owner_s = OWN_NONE;
            state_s = ST_IDLE;
          end
        end
        ST_RESP: begin
          if (mem_rvalid_i) begin
            if_rvalid_o  = (owner_r == OWN_IF);
            lsu_rvalid_o = (owner_r == OWN_LSU);
            if_rdata_o   = (owner_r == OWN_IF)  ? mem_rdata_i : 32'h0000_0000;
            lsu_rdata_o  = (owner_r == OWN_LSU) ? mem_rdata_i : 32'h0000_0000;
            owner_s      = OWN_NONE;
            state_s      = ST_IDLE;
          end else begin
            state_s = ST_RESP;
          end
        end
        default: begin
          owner_s = OWN_NONE;
          state_s = ST_IDLE;
        end
      endcase

      case (sel_s)
        OWN_IF: begin
          mem_req_o  = 1'b1;
          mem_be_o   = 4'hF;
          mem_addr_o = if_addr_i;
          if_gnt_o   = mem_gnt_i;
        end
        OWN_LSU: begin
          mem_req_o   = 1'b1;
          mem_we_o    = lsu_we_i;
          mem_be_o    = lsu_be_i;
          mem_addr_o  = lsu_addr_i;
          mem_wdata_o = lsu_wdata_i;
          lsu_gnt_o   = mem_gnt_i;
        end
        default: begin
          mem_req_o = 1'b0;
        end
      endcase

      if (if_gnt_o) begin
        starve_s = {CW{1'b0}};
      end else begin
        starve_s = starve_s;
      end
    end
  end

  assign protocol_err_o = protocol_err_r;

`ifdef MEM_ARB_PERF_CNT_EN
  logic [CNT_W-1:0] if_stall_r, lsu_stall_r, conflict_r;

  // Saturating stall and conflict counters
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      if_stall_r  <= {CNT_W{1'b0}};
      lsu_stall_r <= {CNT_W{1'b0}};
      conflict_r  <= {CNT_W{1'b0}};
    end else begin
      if (if_req_i && !if_gnt_o && (if_stall_r != {CNT_W{1'b1}})) begin
        if_stall_r <= if_stall_r + CNT_W'(1);
      end
      if (lsu_req_i && !lsu_gnt_o && (lsu_stall_r != {CNT_W{1'b1}})) begin
        lsu_stall_r <= lsu_stall_r + CNT_W'(1);
      end
      if (conflict_s && (state_r == ST_IDLE) && (conflict_r != {CNT_W{1'b1}})) begin
        conflict_r <= conflict_r + CNT_W'(1);
      end
    end
  end

  assign if_stall_cnt_o  = if_stall_r;
  assign lsu_stall_cnt_o = lsu_stall_r;
  assign conflict_cnt_o  = conflict_r;
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates the single main-memory port between instruction fetch (IF) and the load/store unit (LSU).
- Sits between IF_Stage/Mem_Stage and DRAM; replaces the shared grant wiring with an explicit request/grant/response protocol.
- LSU has priority by default. A starvation guard bounds how long IF can be held off.
- At most one transaction is outstanding.

Parameters:
- MAX_IF_WAIT, 4: consecutive lost conflicts after which IF wins the next conflict; 0 = strict LSU priority.
- CNT_W, 16: width of the performance counters (optional feature only).

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- if_req_i  in  1  IF read request; held stable until if_gnt_o
- if_addr_i  in  32  IF word address
- if_gnt_o  out  1  IF request accepted by memory this cycle
- if_rvalid_o  out  1  IF read data valid
- if_rdata_o  out  32  IF read data
- lsu_req_i  in  1  LSU request; held stable until lsu_gnt_o
- lsu_we_i  in  1  1 = store, 0 = load
- lsu_be_i  in  4  byte enables
- lsu_addr_i  in  32  data address
- lsu_wdata_i  in  32  store data
- lsu_gnt_o  out  1  LSU request accepted
- lsu_rvalid_o  out  1  load data / store ack valid
- lsu_rdata_o  out  32  load data
- mem_req_o  out  1  request to DRAM
- mem_we_o  out  1  write enable to DRAM
- mem_be_o  out  4  byte enables to DRAM
- mem_addr_o  out  32  address to DRAM
- mem_wdata_o  out  32  write data to DRAM
- mem_gnt_i  in  1  DRAM accepts the request this cycle
- mem_rvalid_i  in  1  DRAM response valid (reads and writes)
- mem_rdata_i  in  32  DRAM read data
- busy_o  out  1  state != IDLE
- protocol_err_o  out  1  sticky: mem_rvalid_i seen outside RESP

Behaviour:
- Reset (reset=0, async): state=IDLE, owner=NONE, starvation counter=0, protocol_err_o=0; all outputs 0. A pending transaction is dropped with no rvalid to any requester.
- States:
  - IDLE: no transaction active.
  - HOLD: winner chosen, waiting for mem_gnt_i.
  - RESP: granted, waiting for mem_rvalid_i.
- IDLE arbitration (combinational):
  - Only one requester active: it wins.
  - Both active: LSU wins, unless MAX_IF_WAIT>0 and starve_cnt==MAX_IF_WAIT, in which case IF wins.
- Winner's fields drive mem_* combinationally in the same cycle (zero added latency). mem_we_o=0 and mem_be_o=4'hF for IF.
- In IDLE with a winner:
  - mem_gnt_i=1: the winner's *_gnt_o=1 this cycle; latch owner; go to RESP.
  - mem_gnt_i=0: latch owner; go to HOLD.
- HOLD:
  - mem_* driven from the latched owner's inputs; no re-arbitration (lock).
  - On mem_gnt_i, the owner's gnt_o=1 and state goes to RESP.
  - If the owner drops its request (protocol violation), return to IDLE with no grant.
- RESP:
  - mem_req_o=0.
  - On mem_rvalid_i, the owner's rvalid_o=1 and rdata_o=mem_rdata_i in the same cycle; go to IDLE.
  - The next arbitration happens the following cycle, so there is a 1-cycle bubble per transaction.
- rdata_o of the non-owner is 0. The rvalid_o of a non-owner never asserts.
- Starvation counter:
  - Increments (saturating at MAX_IF_WAIT) on each IDLE decision where both requested and LSU won.
  - Clears when IF is granted.
  - Width is $clog2(MAX_IF_WAIT+1), minimum 1.
- mem_rvalid_i in IDLE/HOLD is ignored for routing and sets protocol_err_o; only reset clears it.
- Simultaneous mem_gnt_i and mem_rvalid_i in IDLE: the grant is processed normally, the rvalid raises the error flag only.
- Latency: request accepted at cycle N; response at the first mem_rvalid_i at N+1 or later.

Optional Feature:
- Macro: MEM_ARB_PERF_CNT_EN.
- When defined:
  - Adds outputs if_stall_cnt_o[CNT_W-1:0] (cycles with if_req_i=1 and if_gnt_o=0) and lsu_stall_cnt_o[CNT_W-1:0] (same for LSU).
  - Adds conflict_cnt_o[CNT_W-1:0] (IDLE cycles with both requests active).
  - All counters saturate at all-ones and clear on reset.
- When undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- IF only, addr 0x10, DRAM gnt same cycle, rvalid next cycle with 0x00A00093 -> if_gnt_o at N, if_rvalid_o and if_rdata_o=0x00A00093 at N+1, busy_o high 1 cycle.
- IF and LSU store (addr 0x200, wdata 0xDEADBEEF, be 4'hF) request together, MAX_IF_WAIT=4 -> LSU granted first with mem_we_o=1; IF granted in the next IDLE; starve_cnt 1 then 0.
- Both requesters held continuously for 5 conflicts, LSU re-requesting immediately each time -> LSU wins 4, IF wins the 5th; with MAX_IF_WAIT=0, LSU wins all 5.
- DRAM withholds mem_gnt_i 3 cycles while LSU holds a load and IF raises a request mid-HOLD -> mem_addr_o stays the LSU address; lsu_gnt_o on cycle 4; no if_gnt_o before LSU rvalid.
- reset pulled low during RESP, then a stray mem_rvalid_i after release -> no rvalid to either requester; state IDLE; protocol_err_o=1.
- With MEM_ARB_PERF_CNT_EN: 3 conflict cycles, IF stalled 6 cycles -> conflict_cnt_o=3, if_stall_cnt_o=6.
